// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch queue.
// Holds the fetch FSM states, PC width, reset PC and the FIFO entry layout.
package fetch_pkg;

  localparam int PC_W = 8;
  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 8'h00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } state_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] instr;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc,instr}; push lands one edge later, head is combinational (zero when empty).
// No internal backpressure: the producer guarantees it never pushes into a full queue; flush wins.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [ENTRY_W-1:0]         push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [ENTRY_W-1:0]         head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues one read per cycle while slots remain, data enters the FIFO 1 edge after issue.
// Decode backpressure via instr_ready stops issue once occupancy+inflight reaches DEPTH; FETCH_STALL_CNT_EN adds stall_count.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clock,
  input  logic            reset,
  output logic [PC_W-1:0] mem_addr,
  output logic            mem_rd,
  input  logic [PC_W-1:0] mem_q,
  output logic [PC_W-1:0] instr,
  output logic [PC_W-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            halt,
  output logic [15:0]     fetch_count
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [15:0]     stall_count
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t          state, state_n;
  logic [PC_W-1:0] pc;
  logic            inflight;
  logic [PC_W-1:0] inflight_pc;
  logic [CW-1:0]   count;
  logic [CW:0]     pending;
  logic            issue;
  logic            push;
  logic            pop;
  entry_t          push_entry;
  entry_t          head_entry;
  logic [ENTRY_W-1:0] head_bits;

  // Reserve a FIFO slot for the in-flight read so a push never meets a full queue.
  assign pending  = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign issue    = (state == FETCH) && !halt && !redirect && (pending < (CW+1)'(DEPTH));
  assign mem_rd   = issue;
  assign mem_addr = pc;

  assign instr_valid = (count != '0);
  assign push        = inflight && !redirect;
  assign pop         = instr_valid && instr_ready && !redirect;

  assign push_entry = '{pc: inflight_pc, instr: mem_q};
  assign head_entry = entry_t'(head_bits);
  assign instr      = head_entry.instr;
  assign instr_pc   = head_entry.pc;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = FETCH;
      FETCH:   if (halt) state_n = HALTED;
      HALTED:  if (!halt) state_n = FETCH;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      fetch_count <= '0;
    end else begin
      state    <= state_n;
      inflight <= issue;
      if (issue) inflight_pc <= pc;
      if (redirect)   pc <= redirect_pc;
      else if (issue) pc <= pc + 1'b1;
      if (pop) fetch_count <= fetch_count + 1'b1;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (redirect) begin
      stall_count <= '0;
    end else if ((state != IDLE) && !instr_valid && instr_ready && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 1'b1;
    end
  end
`endif

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect),
    .head      (head_bits),
    .count     (count)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue against a one-cycle-latency memory returning addr+8'h10.
// Covers reset, streaming, backpressure, redirect flush, PC wrap, halt and mid-flight reset.
module tb_fetch_queue;

  logic        clock;
  logic        reset;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_q;
  logic [7:0]  instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        halt;
  logic [15:0] fetch_count;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int issued;

  fetch_queue #(
    .DEPTH    (4),
    .RESET_PC (8'h00)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_q       (mem_q),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .fetch_count (fetch_count)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_count (stall_count)
`endif
  );

  always #5 clock = ~clock;

  // Instruction memory: word at address a is a+8'h10, valid the cycle after the read edge.
  always @(posedge clock) begin
    if (mem_rd) mem_q <= mem_addr + 8'h10;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    clock       = 1'b0;
    reset       = 1'b0;
    mem_q       = 8'h00;
    instr_ready = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
    halt        = 1'b0;
    #1;

    // Reset state
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", 32'(instr), 32'h00);
    check("rst_instr_pc", 32'(instr_pc), 32'h00);
    check("rst_fetch_count", 32'(fetch_count), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'h00);

    // Streaming from reset: IDLE edge, issue edge, push edge
    do_reset();
    tick();
    check("start_mem_rd", 32'(mem_rd), 32'd1);
    check("start_addr0", 32'(mem_addr), 32'h00);
    tick();
    check("start_addr1", 32'(mem_addr), 32'h01);
    check("start_valid_early", 32'(instr_valid), 32'd0);
    tick();
    check("first_valid", 32'(instr_valid), 32'd1);
    check("first_instr", 32'(instr), 32'h10);
    check("first_pc", 32'(instr_pc), 32'h00);
    tick();
    check("second_instr", 32'(instr), 32'h11);
    check("second_pc", 32'(instr_pc), 32'h01);
    check("stream_count", 32'(fetch_count), 32'd1);

    // Backpressure: only DEPTH requests while decode stalls
    do_reset();
    instr_ready = 1'b0;
    issued = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_rd) issued++;
    end
    check("bp_issued", 32'(issued), 32'd4);
    check("bp_mem_rd_off", 32'(mem_rd), 32'd0);
    check("bp_head", 32'(instr), 32'h10);
    instr_ready = 1'b1;
    tick();
    check("bp_pop1", 32'(instr), 32'h11);
    check("bp_count1", 32'(fetch_count), 32'd1);
    tick();
    check("bp_pop2", 32'(instr), 32'h12);
    tick();
    check("bp_pop3", 32'(instr), 32'h13);

    // Redirect with FIFO at 3 entries plus one read in flight
    do_reset();
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("pre_redir_valid", 32'(instr_valid), 32'd1);
    redirect    = 1'b1;
    redirect_pc = 8'h40;
    instr_ready = 1'b1;
    tick();
    redirect = 1'b0;
    #1;
    check("redir_valid0", 32'(instr_valid), 32'd0);
    check("redir_count", 32'(fetch_count), 32'd0);
    check("redir_addr", 32'(mem_addr), 32'h40);
    check("redir_mem_rd", 32'(mem_rd), 32'd1);
    tick();
    check("redir_valid1", 32'(instr_valid), 32'd0);
    tick();
    check("redir_valid2", 32'(instr_valid), 32'd1);
    check("redir_pc", 32'(instr_pc), 32'h40);
    check("redir_instr", 32'(instr), 32'h50);

    // Redirect near the top of the PC space; same-edge pop must not count
    redirect    = 1'b1;
    redirect_pc = 8'hFE;
    tick();
    redirect = 1'b0;
    check("wrap_no_count", 32'(fetch_count), 32'd0);
    tick();
    tick();
    check("wrap_pc_fe", 32'(instr_pc), 32'hFE);
    check("wrap_instr_fe", 32'(instr), 32'h0E);
    tick();
    check("wrap_pc_ff", 32'(instr_pc), 32'hFF);
    tick();
    check("wrap_pc_00", 32'(instr_pc), 32'h00);
    check("wrap_instr_00", 32'(instr), 32'h10);
    tick();
    check("wrap_pc_01", 32'(instr_pc), 32'h01);
    check("wrap_count", 32'(fetch_count), 32'd3);

    // Halt with a read in flight (PC 02) while decode stalls
    halt        = 1'b1;
    instr_ready = 1'b0;
    #1;
    check("halt_mem_rd_now", 32'(mem_rd), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("halt_mem_rd", 32'(mem_rd), 32'd0);
    end
    check("halt_head", 32'(instr_pc), 32'h01);
    halt        = 1'b0;
    instr_ready = 1'b1;
    tick();
    check("resume_queued_pc", 32'(instr_pc), 32'h02);
    check("resume_addr", 32'(mem_addr), 32'h03);
    check("resume_mem_rd", 32'(mem_rd), 32'd1);
    tick();
    check("resume_count", 32'(fetch_count), 32'd5);
    tick();
    check("resume_pc", 32'(instr_pc), 32'h03);
    check("resume_instr", 32'(instr), 32'h13);

    // Asynchronous reset in the middle of a cycle
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(instr_valid), 32'd0);
    check("mid_rst_instr", 32'(instr), 32'h00);
    check("mid_rst_pc", 32'(instr_pc), 32'h00);
    check("mid_rst_mem_rd", 32'(mem_rd), 32'd0);
    check("mid_rst_count", 32'(fetch_count), 32'd0);
    check("mid_rst_addr", 32'(mem_addr), 32'h00);
`ifdef FETCH_STALL_CNT_EN
    check("mid_rst_stall", 32'(stall_count), 32'd0);
`endif
    tick();
    reset = 1'b1;
    tick();
    check("restart_addr", 32'(mem_addr), 32'h00);
    tick();
    tick();
    check("restart_valid", 32'(instr_valid), 32'd1);
    check("restart_pc", 32'(instr_pc), 32'h00);
    check("restart_count", 32'(fetch_count), 32'd0);
`ifdef FETCH_STALL_CNT_EN
    check("restart_stall", 32'(stall_count), 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
